shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one combinational shifter (SLL/SRL/SRA) between two requesters.
- Each requester uses a valid/ready request channel. A single registered response channel returns the result tagged with the requester ID.
- Round-robin arbitration, one-cycle latency, back-to-back throughput of one op per cycle.
- Sits between the ALU issue logic and the shift datapath, where the shifter is too large to duplicate.

Parameters:
- N, 32, data width; shift amount width is $clog2(N).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an op.
- req0_ready  output  1  requester 0 op accepted this cycle.
- req0_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 illegal.
- req0_in  input  N  operand.
- req0_shamt  input  $clog2(N)  shift amount.
- req1_valid, req1_ready, req1_op, req1_in, req1_shamt  same as requester 0, for requester 1.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer takes response.
- rsp_id  output  1  requester that issued the response.
- rsp_data  output  N  shift result.
- rsp_err  output  1  op was 11.

Behaviour:
- Async reset:
  - state=IDLE; rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - last_grant=1, so requester 0 wins the first tie.
  - A response in flight is dropped; nothing is accepted while rst=1.
- States:
  - IDLE: no response held.
  - RESP: rsp_valid=1, response registers stable.
- can_accept = (state==IDLE) || (rsp_ready). rsp_ready is only meaningful in RESP; in IDLE it is a don't-care.
- Grant, evaluated combinationally each cycle:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant !last_grant.
- reqX_ready = can_accept && grant==X. Ready may depend combinationally on valid. At most one ready is high per cycle.
- Accept: a rising edge with reqX_valid && reqX_ready.
  - Selected operands drive the shifter.
  - rsp_data, rsp_id=X and rsp_err are registered; last_grant=X; state goes to RESP.
  - Latency: accepted at edge k, rsp_valid visible after edge k.
- In RESP:
  - rsp_ready=1 with a new accept: load the new response, stay in RESP. This gives back-to-back operation.
  - rsp_ready=1 with no accept: go to IDLE, rsp_valid=0. rsp_data/rsp_id/rsp_err keep their last value.
  - rsp_ready=0: hold all rsp_* stable; both readies low.
- Arithmetic:
  - SLL: zero-fill from the LSB side.
  - SRL: zero-fill from the MSB side.
  - SRA: replicate in[N-1].
  - shamt 0 gives the operand unchanged for all three ops.
  - shamt N-1 gives bit 0 moved to MSB (SLL), bit N-1 moved to LSB (SRL), or all sign bits (SRA).
- Illegal op 11: accepted normally, rsp_data=0, rsp_err=1, last_grant still updates.
- A requester holding valid while not granted must keep its operands stable (AXI-style). The block does not check this.
- Starvation-free: with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1…

Decomposition:
- Package shift_pkg:
  - enum shift_op_t {SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ILL=2'b11}.
  - enum arb_state_t {IDLE, RESP}.
- Sub-module shift_core(in, shamt, op, out):
  - Combinational. Instantiates the team's sra component for SRA, plus left/right logical barrel shifts with the same mux structure, then a 3:1 select.
  - shift_arbiter contains only the arbiter, FSM and response registers.

Test Plan:
- Reset, then req0 SRA in=32'h8000_0000, shamt=4, rsp_ready=1: req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=32'hF800_0000, rsp_err=0.
- Both valid every cycle, rsp_ready=1, req0 SLL 32'h1 shamt=31, req1 SRL 32'h8000_0000 shamt=31: responses alternate id 0,1,0,1 with data 32'h8000_0000 / 32'h1; one response per cycle, no gaps.
- Response held with rsp_ready=0 for 5 cycles while both request: both readies low, rsp_* stable; on rsp_ready=1, the next grant goes to the requester not last served.
- req1 op=11 in=32'hDEAD_BEEF: rsp_err=1, rsp_data=0, rsp_id=1; the following tie is granted to 0.
- Assert rst mid-RESP with rsp_ready=0: rsp_valid drops immediately, asynchronously. After release, a simultaneous tie is granted to req0.
- SRA sweep with shamt 0..31 on 32'h7FFF_FFFF and 32'h8000_0001: rsp_data equals $signed(in)>>>shamt for every case.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the two-requester shift arbiter and its shifter core.
package shift_pkg;
  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ILL = 2'b11
  } shift_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;
endpackage

// File: rtl/shift_core.sv
// Combinational SLL/SRL/SRA shifter; the illegal op encoding yields zero.
module shift_core
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]         in,
  input  logic [$clog2(N)-1:0] shamt,
  input  shift_op_t            op,
  output logic [N-1:0]         out
);
  localparam int SW = $clog2(N);

  logic [N-1:0] w_sll [SW+1];
  logic [N-1:0] w_srl [SW+1];
  logic [N-1:0] w_sra;

  assign w_sll[0] = in;
  assign w_srl[0] = in;

  // Logical shifters share the staged-mux layout of the arithmetic one.
  for (genvar s = 0; s < SW; s++) begin : g_stage
    assign w_sll[s+1] = shamt[s] ? {w_sll[s][N-1-2**s:0], {(2**s){1'b0}}} : w_sll[s];
    assign w_srl[s+1] = shamt[s] ? {{(2**s){1'b0}}, w_srl[s][N-1:2**s]} : w_srl[s];
  end

  shift_sra #(.N(N)) u_sra (
    .i_in    (in),
    .i_shamt (shamt),
    .o_out   (w_sra)
  );

  always_comb begin
    out = '0;
    unique case (op)
      SHIFT_SLL: out = w_sll[SW];
      SHIFT_SRL: out = w_srl[SW];
      SHIFT_SRA: out = w_sra;
      default:   out = '0;
    endcase
  end
endmodule

// File: rtl/shift_sra.sv
// Arithmetic right barrel shifter: log2(N) mux stages, sign bit fills from the MSB side.
module shift_sra #(
  parameter int N = 32
) (
  input  logic [N-1:0]         i_in,
  input  logic [$clog2(N)-1:0] i_shamt,
  output logic [N-1:0]         o_out
);
  localparam int SW = $clog2(N);

  logic [N-1:0] w_stage [SW+1];

  assign w_stage[0] = i_in;

  for (genvar s = 0; s < SW; s++) begin : g_stage
    assign w_stage[s+1] = i_shamt[s]
                        ? {{(2**s){w_stage[s][N-1]}}, w_stage[s][N-1:2**s]}
                        : w_stage[s];
  end

  assign o_out = w_stage[SW];
endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between two valid/ready requesters,
// with a single registered, ID-tagged response channel.
//   state | meaning
//   IDLE  | no response held
//   RESP  | rsp_valid high, response registers stable until consumed
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [N-1:0]         req0_in,
  input  logic [$clog2(N)-1:0] req0_shamt,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [N-1:0]         req1_in,
  input  logic [$clog2(N)-1:0] req1_shamt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [N-1:0]         rsp_data,
  output logic                 rsp_err
);
  localparam int SW = $clog2(N);

  arb_state_t   r_state;
  logic         r_last_grant;
  logic         r_rsp_id;
  logic         r_rsp_err;
  logic [N-1:0] r_rsp_data;

  logic          w_can_accept;
  logic          w_grant;
  logic          w_accept;
  logic [1:0]    w_sel_op;
  logic [N-1:0]  w_sel_in;
  logic [SW-1:0] w_sel_shamt;
  logic [N-1:0]  w_shift_out;

  // Nothing is offered ready while reset holds the registers.
  assign w_can_accept = ~rst & ((r_state == IDLE) | rsp_ready);

  always_comb begin
    w_grant = req1_valid;
    if (req0_valid && req1_valid) w_grant = ~r_last_grant;
  end

  assign req0_ready = w_can_accept & ~w_grant;
  assign req1_ready = w_can_accept &  w_grant;
  assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign w_sel_op    = w_grant ? req1_op    : req0_op;
  assign w_sel_in    = w_grant ? req1_in    : req0_in;
  assign w_sel_shamt = w_grant ? req1_shamt : req0_shamt;

  shift_core #(.N(N)) u_core (
    .in    (w_sel_in),
    .shamt (w_sel_shamt),
    .op    (shift_op_t'(w_sel_op)),
    .out   (w_shift_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= RESP;
            r_last_grant <= w_grant;
            r_rsp_id     <= w_grant;
            r_rsp_err    <= (w_sel_op == SHIFT_ILL);
            r_rsp_data   <= w_shift_out;
          end
        end
        RESP: begin
          if (w_accept) begin
            r_last_grant <= w_grant;
            r_rsp_id     <= w_grant;
            r_rsp_err    <= (w_sel_op == SHIFT_ILL);
            r_rsp_data   <= w_shift_out;
          end else if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
endmodule
